// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Multi-cycle controller that runs one register-to-register ALU
//            instruction at a time over a single-port 8x16 register bank.
//            Operands are read one per cycle through rb_sel, the ALU result
//            is registered, then written back to the destination register.
// Ports    : clock / reset (active-low, async assert)
//            instr_valid, instr[15:0], instr_ready   - instruction handshake
//              instr[11:9]=f, [8:6]=rd, [5:3]=rs, [2:0]=rt, [15:12] ignored
//            done (1-cycle retire pulse), busy (state != IDLE)
//            rb_sel, rb_write, rb_wdata, rb_rdata    - register bank port
//            alu_x, alu_y, alu_f, alu_z, alu_cy, alu_cym1 - ALU port
//            flags[3:0] = {N, Z, C, V}
// Config   : ALU_SEQ_FLAGS_EN - when defined, the status-flag register is
//            built; otherwise flags is tied to 4'b0000.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        done,
    output logic        busy,
    output logic [2:0]  rb_sel,
    output logic        rb_write,
    output logic [15:0] rb_wdata,
    input  logic [15:0] rb_rdata,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [2:0]  alu_f,
    input  logic [15:0] alu_z,
    input  logic        alu_cy,
    input  logic        alu_cym1,
    output logic [3:0]  flags
);

    localparam logic [2:0] c_F_INC = 3'b001;
    localparam logic [2:0] c_F_ADD = 3'b010;
    localparam logic [2:0] c_F_OR  = 3'b100;
    localparam logic [2:0] c_F_DEC = 3'b110;
    localparam logic [2:0] c_F_NOP = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDX  = 3'd1,
        S_RDY  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [11:0] r_instr;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_z;

    logic [2:0]  w_f;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs;
    logic [2:0]  w_rt;
    logic        w_binary;

    assign w_f      = r_instr[11:9];
    assign w_rd     = r_instr[8:6];
    assign w_rs     = r_instr[5:3];
    assign w_rt     = r_instr[2:0];
    assign w_binary = (w_f == c_F_ADD) || (w_f == c_F_OR);
    assign busy     = (r_state != S_IDLE);

    // State and datapath registers. Y is cleared in RDX so unary ops see 0;
    // binary ops overwrite it in RDY.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: if (instr_valid && instr_ready) r_instr <= instr[11:0];
                S_RDX: begin
                    r_x <= rb_rdata;
                    r_y <= '0;
                end
                S_RDY:  r_y <= rb_rdata;
                S_EXEC: r_z <= alu_z;
                default: ;
            endcase
        end
    end

    // Next-state and output decode; every output idles at 0.
    always_comb begin
        w_state_next = r_state;
        instr_ready  = 1'b0;
        done         = 1'b0;
        rb_sel       = 3'd0;
        rb_write     = 1'b0;
        rb_wdata     = 16'h0000;
        alu_x        = 16'h0000;
        alu_y        = 16'h0000;
        alu_f        = 3'd0;
        case (r_state)
            S_IDLE: begin
                // Gated by reset so ready drops the moment reset asserts.
                instr_ready = reset;
                if (instr_valid && reset) w_state_next = S_RDX;
            end
            S_RDX: begin
                rb_sel       = w_rs;
                w_state_next = w_binary ? S_RDY : S_EXEC;
            end
            S_RDY: begin
                rb_sel       = w_rt;
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                alu_x        = r_x;
                alu_y        = r_y;
                alu_f        = w_f;
                w_state_next = S_WB;
            end
            S_WB: begin
                rb_sel       = w_rd;
                rb_wdata     = r_z;
                rb_write     = (w_f != c_F_NOP);
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic [3:0] r_flags;
    logic       w_arith;
    logic       w_unused_instr;

    // Only the adder-type functions produce a meaningful carry/overflow.
    assign w_arith = (w_f == c_F_INC) || (w_f == c_F_ADD) || (w_f == c_F_DEC);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else if ((r_state == S_EXEC) && (w_f != c_F_NOP)) begin
            r_flags[3] <= alu_z[15];
            r_flags[2] <= (alu_z == 16'h0000);
            if (w_arith) begin
                r_flags[1] <= alu_cy;
                r_flags[0] <= alu_cy ^ alu_cym1;
            end
        end
    end

    assign flags          = r_flags;
    assign w_unused_instr = &{1'b0, instr[15:12]};
`else
    logic w_unused_instr;

    assign flags          = 4'b0000;
    assign w_unused_instr = &{1'b0, instr[15:12], alu_cy, alu_cym1};
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Directed self-checking bench for alu_op_sequencer with a
//            register-bank model and an ALU model attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_FLAGS_EN
    localparam bit c_FL_EN = 1'b1;
`else
    localparam bit c_FL_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        done;
    logic        busy;
    logic [2:0]  rb_sel;
    logic        rb_write;
    logic [15:0] rb_wdata;
    logic [15:0] rb_rdata;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [2:0]  alu_f;
    logic [15:0] alu_z;
    logic        alu_cy;
    logic        alu_cym1;
    logic [3:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;
    logic wr_seen = 1'b0;
    logic y_bad   = 1'b0;

    logic [15:0] rb [8];

    alu_op_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .done        (done),
        .busy        (busy),
        .rb_sel      (rb_sel),
        .rb_write    (rb_write),
        .rb_wdata    (rb_wdata),
        .rb_rdata    (rb_rdata),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_f       (alu_f),
        .alu_z       (alu_z),
        .alu_cy      (alu_cy),
        .alu_cym1    (alu_cym1),
        .flags       (flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register bank: combinational read, write at the clock edge.
    assign rb_rdata = rb[rb_sel];
    always @(posedge clock) if (rb_write) rb[rb_sel] = rb_wdata;

    // ALU model: 17-bit sum gives carry out of bit 15, 16-bit sum of the low
    // 15 bits gives carry out of bit 14.
    function automatic logic [17:0] add3(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] l;
        s = {1'b0, a} + {1'b0, b};
        l = {1'b0, a[14:0]} + {1'b0, b[14:0]};
        return {s[16], l[15], s[15:0]};
    endfunction

    always_comb begin
        logic [17:0] r;
        r        = 18'h0;
        alu_z    = alu_x;
        alu_cy   = 1'b0;
        alu_cym1 = 1'b0;
        case (alu_f)
            3'b001: r = add3(alu_x, 16'h0001);
            3'b010: r = add3(alu_x, alu_y);
            3'b110: r = add3(alu_x, 16'hFFFF);
            default: r = 18'h0;
        endcase
        case (alu_f)
            3'b001, 3'b010, 3'b110: begin
                alu_z    = r[15:0];
                alu_cym1 = r[16];
                alu_cy   = r[17];
            end
            3'b011: alu_z = ~alu_x;
            3'b100: alu_z = alu_x | alu_y;
            3'b101: alu_z = alu_x & alu_y;
            default: alu_z = alu_x;
        endcase
    end

    always @(negedge clock) begin
        if (rb_write) wr_seen = 1'b1;
        if (busy && (alu_f == 3'b001) && (alu_y != 16'h0000)) y_bad = 1'b1;
    end

    function automatic logic [3:0] fx(input logic [3:0] v);
        return c_FL_EN ? v : 4'b0000;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered in cycle T+1; checks done arrives at T+lat and ready returns after.
    task automatic wait_done(input string tag, input int lat);
        int   dcyc;
        logic rdy_seen;
        dcyc     = 0;
        rdy_seen = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            rdy_seen = rdy_seen | instr_ready;
            if (done) begin
                dcyc = k;
                break;
            end
            tick();
        end
        chk({tag, "_done_lat"}, 32'(dcyc), 32'(lat));
        chk({tag, "_rdy_low"}, 32'(rdy_seen), 32'd0);
        tick();
        chk({tag, "_rdy_back"}, 32'(instr_ready), 32'd1);
    endtask

    task automatic issue(input string tag, input logic [15:0] ins, input int lat);
        instr       = ins;
        instr_valid = 1'b1;
        chk({tag, "_rdy_T"}, 32'(instr_ready), 32'd1);
        tick();
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
        wait_done(tag, lat);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        rb[0] = 16'hAAAA; rb[1] = 16'h7FFF; rb[2] = 16'h0001; rb[3] = 16'h1234;
        rb[4] = 16'h5555; rb[5] = 16'hFFFF; rb[6] = 16'h0000; rb[7] = 16'h0000;
        #2 reset = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_write", 32'(rb_write),    32'd0);
        chk("rst_flags", 32'(flags),       32'd0);
        chk("rst_alux",  32'(alu_x),       32'd0);
        reset = 1'b1;
        tick();
        chk("rel_ready", 32'(instr_ready), 32'd1);

        // add R3 = R1 + R2 : 0x7FFF + 1 -> signed overflow
        issue("add", 16'h04CA, 4);
        chk("add_r3",    32'(rb[3]), 32'h8000);
        chk("add_flags", 32'(flags), 32'(fx(4'b1001)));

        // inc R4 = R5 + 1 : 0xFFFF wraps to 0 with carry
        issue("inc", 16'h0328, 3);
        chk("inc_r4",    32'(rb[4]), 32'h0000);
        chk("inc_flags", 32'(flags), 32'(fx(4'b0110)));

        // or R1 = R1 | R2 : carry retained
        rb[1] = 16'h00F0;
        rb[2] = 16'h0F00;
        issue("or", 16'h084A, 4);
        chk("or_r1",    32'(rb[1]), 32'h0FF0);
        chk("or_flags", 32'(flags), 32'(fx(4'b0010)));

        // NOP : no write, flags untouched
        wr_seen = 1'b0;
        issue("nop", 16'h0E00, 3);
        chk("nop_nowrite", 32'(wr_seen), 32'd0);
        chk("nop_r0",      32'(rb[0]),   32'hAAAA);
        chk("nop_flags",   32'(flags),   32'(fx(4'b0010)));

        // Back-to-back adds with instr_valid held high
        instr       = 16'h058A;     // add R6 = R1 + R2
        instr_valid = 1'b1;
        chk("b2b_rdy_T", 32'(instr_ready), 32'd1);
        tick();
        instr = 16'hF5F6;           // add R7 = R6 + R6, upper nibble junk
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("b2b_rdy_T%0d", k), 32'(instr_ready), 32'd0);
            tick();
        end
        chk("b2b_rdy_T5", 32'(instr_ready), 32'd1);
        chk("b2b_r6",     32'(rb[6]),       32'h1EF0);
        tick();
        instr_valid = 1'b0;
        wait_done("b2b2", 4);
        chk("b2b_r7",    32'(rb[7]), 32'h3DE0);
        chk("b2b_flags", 32'(flags), 32'(fx(4'b0000)));

        // Set nonzero flags, then abort an add in EXEC with reset
        issue("prep", 16'h0328, 3);
        chk("prep_flags", 32'(flags), 32'(fx(4'b0110)));
        instr       = 16'h04CA;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        chk("exec_f", 32'(alu_f), 32'd2);
        chk("exec_x", 32'(alu_x), 32'h0FF0);
        chk("exec_y", 32'(alu_y), 32'h0F00);
        wr_seen = 1'b0;
        reset   = 1'b0;
        #1;
        chk("abort_ready", 32'(instr_ready), 32'd0);
        chk("abort_busy",  32'(busy),        32'd0);
        chk("abort_sel",   32'(rb_sel),      32'd0);
        chk("abort_f",     32'(alu_f),       32'd0);
        chk("abort_flags", 32'(flags),       32'd0);
        tick();
        tick();
        chk("abort_ready2", 32'(instr_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("abort_rel_ready", 32'(instr_ready), 32'd1);
        chk("abort_rel_flags", 32'(flags),       32'd0);
        chk("abort_nowrite",   32'(wr_seen),     32'd0);
        chk("abort_r3",        32'(rb[3]),       32'h8000);

        // inc R7 = R5 + 1 after recovery
        issue("post", 16'h03E8, 3);
        chk("post_r7",    32'(rb[7]), 32'h0000);
        chk("post_flags", 32'(flags), 32'(fx(4'b0110)));

        chk("unary_y_zero", 32'(y_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
